// File: rtl/mem_arb_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding
// and requester port identifiers.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic P_IF = 1'b0;
    localparam logic P_LS = 1'b1;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin picker: a lone requester wins outright, and on a
// tie the port that was not served last wins.
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_valid,
    output logic       o_pick
);

    // Bit 0 of the request vector is the fetch port, bit 1 the load/store port.
    always_comb begin
        o_valid = |i_req;
        o_pick  = P_IF;
        case (i_req)
            2'b01:   o_pick = P_IF;
            2'b10:   o_pick = P_LS;
            2'b11:   o_pick = ~i_last;
            default: o_pick = P_IF;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-ported data memory between the fetch port (read-only)
// and the load/store port, one access per IDLE -> GRANT -> DONE pass.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W = 6,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_ack,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              ls_req,
    input  logic              ls_we,
    input  logic [ADDR_W-1:0] ls_addr,
    input  logic [DATA_W-1:0] ls_wdata,
    output logic              ls_ack,
    output logic [DATA_W-1:0] ls_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    state_t            r_state;
    logic              r_owner;
    logic              r_last;
    logic              r_ifAck;
    logic              r_lsAck;
    logic [DATA_W-1:0] r_ifRdata;
    logic [DATA_W-1:0] r_lsRdata;

    logic              w_pickValid;
    logic              w_pick;
    logic              w_inGrant;

    rr_arb2 u_rrArb (
        .i_req   ({ls_req, if_req}),
        .i_last  (r_last),
        .o_valid (w_pickValid),
        .o_pick  (w_pick)
    );

    // r_last starts at the load/store port so the fetch port wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_owner   <= P_IF;
            r_last    <= P_LS;
            r_ifAck   <= 1'b0;
            r_lsAck   <= 1'b0;
            r_ifRdata <= '0;
            r_lsRdata <= '0;
        end else begin
            r_ifAck <= 1'b0;
            r_lsAck <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_pickValid) begin
                        r_owner <= w_pick;
                        r_state <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    if (r_owner == P_IF) begin
                        r_ifRdata <= mem_rdata;
                        r_ifAck   <= 1'b1;
                    end else begin
                        if (!ls_we) begin
                            r_lsRdata <= mem_rdata;
                        end
                        r_lsAck <= 1'b1;
                    end
                    r_last  <= r_owner;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes live only in GRANT; rst gates the write so an aborted store never commits.
    assign w_inGrant = (r_state == S_GRANT);
    assign mem_read  = w_inGrant && ((r_owner == P_IF) || !ls_we);
    assign mem_write = w_inGrant && (r_owner == P_LS) && ls_we && !rst;
    assign mem_addr  = w_inGrant ? ((r_owner == P_IF) ? if_addr : ls_addr) : '0;
    assign mem_wdata = w_inGrant ? ls_wdata : '0;

    assign if_ack   = r_ifAck;
    assign ls_ack   = r_lsAck;
    assign if_rdata = r_ifRdata;
    assign ls_rdata = r_lsRdata;
    assign busy     = (r_state != S_IDLE);

endmodule
